tmcspi_sequencer: RTL and testbench



---
 rtl/tmcspi_pkg.sv | 27 ++
 rtl/tmcspi_shifter.sv | 82 ++++++++
 rtl/tmcspi_sequencer.sv | 175 +++++++++++++++++
 tb/tb_tmcspi_sequencer.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tmcspi_pkg.sv
// Shared definitions for the TMC SPI sequencer: register-file word map,
// datagram geometry and the sequencing FSM state encoding.
package tmcspi_pkg;

  localparam logic [5:0] CFG       = 6'd0;
  localparam logic [5:0] CTRL      = 6'd1;
  localparam logic [5:0] STAT      = 6'd2;
  localparam logic [5:0] ADDR_BASE = 6'd5;
  localparam logic [5:0] TX_BASE   = 6'd16;
  localparam logic [5:0] RX_BASE   = 6'd32;

  localparam int MAX_ENTRIES = 16;
  localparam int FRAME_BITS  = 40;

  typedef enum logic [3:0] {
    S_POLL,
    S_CFG,
    S_ADDR,
    S_DATA,
    S_SHIFT,
    S_STRX,
    S_STST,
    S_GAP,
    S_FIN
  } state_t;

endpackage

// File: rtl/tmcspi_shifter.sv
// Mode-3 SPI shift engine: one 40-bit datagram per start, MSB first, with a
// half-period divider; every sclk/csn event lands on a half-period tick.
module tmcspi_shifter
  import tmcspi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [FRAME_BITS-1:0] frame,
  input  logic [7:0]            half,
  output logic                  busy,
  output logic                  done,
  output logic [FRAME_BITS-1:0] rx,
  output logic                  sclk,
  output logic                  mosi,
  output logic                  csn,
  input  logic                  miso
);

  // Half-period 1 is the first sclk fall; 2..80 alternate rise/fall; 81 raises csn.
  localparam logic [6:0] LAST_HALF = 7'(2 * FRAME_BITS + 1);

  logic [7:0]            div;
  logic [6:0]            hcnt;
  logic [6:0]            k;
  logic                  tick;
  logic [FRAME_BITS-1:0] sh;

  assign tick = busy && (div == half - 8'd1);
  assign k    = hcnt + 7'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
      div  <= '0;
      hcnt <= '0;
      csn  <= 1'b1;
      sclk <= 1'b1;
      mosi <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          busy <= 1'b1;
          csn  <= 1'b0;
          sclk <= 1'b1;
          mosi <= frame[FRAME_BITS-1];
          div  <= '0;
          hcnt <= '0;
        end
      end else if (tick) begin
        div  <= '0;
        hcnt <= k;
        if (k == LAST_HALF) begin
          busy <= 1'b0;
          done <= 1'b1;
          csn  <= 1'b1;
          mosi <= 1'b0;
        end else if (k[0]) begin
          sclk <= 1'b0;
          // The first bit was already presented when csn fell.
          if (k != 7'd1) mosi <= sh[FRAME_BITS-2];
        end else begin
          sclk <= 1'b1;
        end
      end else begin
        div <= div + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!busy && start)
      sh <= frame;
    else if (tick && k[0] && k != 7'd1 && k != LAST_HALF)
      sh <= {sh[FRAME_BITS-2:0], 1'b0};
    if (tick && !k[0])
      rx <= {rx[FRAME_BITS-2:0], miso};
  end

endmodule

// File: rtl/tmcspi_sequencer.sv
// Autonomous SPI master: on GO, walks the driver address list, sends one
// datagram per entry, writes RX data and status back, then clears GO.
module tmcspi_sequencer
  import tmcspi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  output logic [5:0]  addr,
  output logic [31:0] din,
  output logic        we,
  input  logic [31:0] dout,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic        csn
);

  function automatic logic [4:0] sat_count(input logic [7:0] c);
    return (c > 8'(MAX_ENTRIES)) ? 5'(MAX_ENTRIES) : c[4:0];
  endfunction

  function automatic logic [7:0] half_period(input logic [7:0] h);
    return (h == 8'd0) ? 8'd1 : h;
  endfunction

  // The reset pin keeps its legacy name but is active-high.
  logic rst;
  assign rst = resetn;

  state_t                state_q, state_d;
  logic                  ph_q, ph_d;
  logic [3:0]            i_q, i_d;
  logic [8:0]            gcnt_q, gcnt_d;
  logic [4:0]            n_q, n_d;
  logic [7:0]            h_q, h_d;
  logic [7:0]            abyte_q, abyte_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;

  logic                  start;
  logic                  busy;
  logic                  done;
  logic [FRAME_BITS-1:0] rx;

  tmcspi_shifter u_shifter (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .frame (frame_q),
    .half  (h_q),
    .busy  (busy),
    .done  (done),
    .rx    (rx),
    .sclk  (sclk),
    .mosi  (mosi),
    .csn   (csn),
    .miso  (miso)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_POLL;
      ph_q    <= 1'b0;
      i_q     <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      i_q     <= i_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    n_q     <= n_d;
    h_q     <= h_d;
    abyte_q <= abyte_d;
    frame_q <= frame_d;
  end

  // Reads take two cycles: ph_q=0 presents addr, ph_q=1 consumes dout.
  always_comb begin
    state_d = state_q;
    ph_d    = 1'b0;
    i_d     = i_q;
    gcnt_d  = gcnt_q;
    n_d     = n_q;
    h_d     = h_q;
    abyte_d = abyte_q;
    frame_d = frame_q;
    addr    = CTRL;
    din     = '0;
    we      = 1'b0;
    start   = 1'b0;

    case (state_q)
      S_POLL: begin
        addr = CTRL;
        ph_d = 1'b1;
        if (ph_q && dout[0]) begin
          state_d = S_CFG;
          ph_d    = 1'b0;
        end
      end
      S_CFG: begin
        addr = CFG;
        ph_d = !ph_q;
        if (ph_q) begin
          n_d     = sat_count(dout[7:0]);
          h_d     = half_period(dout[15:8]);
          i_d     = '0;
          state_d = (dout[7:0] == 8'd0) ? S_FIN : S_ADDR;
        end
      end
      S_ADDR: begin
        addr = ADDR_BASE + {4'b0, i_q[3:2]};
        ph_d = !ph_q;
        if (ph_q) begin
          abyte_d = dout[{i_q[1:0], 3'b000} +: 8];
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        addr = TX_BASE + {2'b0, i_q};
        ph_d = !ph_q;
        if (ph_q) begin
          frame_d = {abyte_q, dout};
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        addr  = TX_BASE + {2'b0, i_q};
        start = !ph_q && !busy;
        ph_d  = 1'b1;
        if (done) begin
          state_d = S_STRX;
          ph_d    = 1'b0;
        end
      end
      S_STRX: begin
        we      = 1'b1;
        addr    = RX_BASE + {2'b0, i_q};
        din     = rx[31:0];
        state_d = S_STST;
      end
      S_STST: begin
        we      = 1'b1;
        addr    = STAT;
        din     = {24'h0, rx[FRAME_BITS-1:32]};
        gcnt_d  = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        addr = CTRL;
        if (gcnt_q == {h_q, 1'b0} - 9'd1) begin
          if (({1'b0, i_q} + 5'd1) < n_q) begin
            i_d     = i_q + 4'd1;
            state_d = S_ADDR;
          end else begin
            state_d = S_FIN;
          end
        end else begin
          gcnt_d = gcnt_q + 9'd1;
        end
      end
      S_FIN: begin
        we      = 1'b1;
        addr    = CTRL;
        din     = '0;
        state_d = S_POLL;
      end
      default: state_d = S_POLL;
    endcase
  end

endmodule

// File: tb/tb_tmcspi_sequencer.sv
// Scoreboard bench: expected datagrams and register writes are queued by the
// stimulus; a negedge monitor compares them as the DUT produces them.
module tb_tmcspi_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  addr;
  logic [31:0] din;
  logic        we;
  logic [31:0] dout;
  logic        sclk, mosi, miso, csn;

  logic [31:0] mem [64];
  logic        sw_we;
  logic [5:0]  sw_addr;
  logic [31:0] sw_din;
  logic        loopback;

  int checks = 0;
  int errors = 0;

  typedef struct { logic [5:0] a; logic [31:0] d; } wr_t;
  typedef struct { logic [39:0] bits; int low; int period; } fr_t;
  wr_t exp_wr[$];
  fr_t exp_fr[$];

  bit aborting = 1'b0;
  int nframes  = 0;
  int nb       = 0;

  always #5 clk = ~clk;

  assign miso = loopback ? mosi : 1'b1;

  tmcspi_sequencer dut (
    .clk    (clk),
    .resetn (resetn),
    .addr   (addr),
    .din    (din),
    .we     (we),
    .dout   (dout),
    .sclk   (sclk),
    .mosi   (mosi),
    .miso   (miso),
    .csn    (csn)
  );

  // Register file: block write lands after a software write so it wins.
  always @(posedge clk) begin
    if (sw_we) mem[sw_addr] <= sw_din;
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end

  task automatic sw_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    sw_we = 1'b1; sw_addr = a; sw_din = d;
    @(negedge clk);
    sw_we = 1'b0;
  endtask

  task automatic chk(input string name, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic push_wr(input logic [5:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a; w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_fr(input logic [39:0] b, input int low, input int period);
    fr_t f;
    f.bits = b; f.low = low; f.period = period;
    exp_fr.push_back(f);
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k;
    k = 0;
    while ((exp_wr.size() != 0 || exp_fr.size() != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= budget) begin
      errors++;
      $display("FAIL %s timeout pending_writes=%0d pending_frames=%0d expected 0",
               name, exp_wr.size(), exp_fr.size());
    end
    repeat (5) @(negedge clk);
  endtask

  // Monitor: register writes and SPI datagrams.
  initial begin
    logic        pc, ps;
    logic [39:0] bits;
    int          low, t1, period, cyc;
    wr_t         w;
    fr_t         f;
    pc = 1'b1; ps = 1'b1; bits = '0; low = 0; t1 = 0; period = 0; cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (we === 1'b1) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write got addr=%0d din=%h expected no write", addr, din);
        end else begin
          w = exp_wr.pop_front();
          if (addr !== w.a || din !== w.d) begin
            errors++;
            $display("FAIL write got addr=%0d din=%h expected addr=%0d din=%h", addr, din, w.a, w.d);
          end
        end
      end
      if (pc && !csn) begin
        nframes++; nb = 0; low = 0; bits = '0; period = 0;
      end
      if (!csn) begin
        low++;
        if (!ps && sclk) begin
          bits = {bits[38:0], mosi};
          nb++;
          if (nb == 1) t1 = cyc;
          else if (nb == 2) period = cyc - t1;
        end
      end
      if (!pc && csn) begin
        if (aborting) begin
          aborting = 1'b0;
        end else begin
          checks++;
          if (exp_fr.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame got bits=%h expected no frame", bits);
          end else begin
            f = exp_fr.pop_front();
            if (bits !== f.bits || low != f.low || period != f.period || nb != 40) begin
              errors++;
              $display("FAIL frame got bits=%h low=%0d period=%0d nbits=%0d expected bits=%h low=%0d period=%0d nbits=40",
                       bits, low, period, nb, f.bits, f.low, f.period);
            end
          end
        end
      end
      pc = csn; ps = sclk;
    end
  end

  initial begin
    #2ms;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, nf0;
    bit ok;
    resetn = 1'b1; sw_we = 1'b0; sw_addr = '0; sw_din = '0; loopback = 1'b0;
    for (int k = 0; k < 64; k++) sw_write(6'(k), 32'h0);
    repeat (10) @(negedge clk);
    chk("reset_csn", 40'(csn), 40'd1);
    chk("reset_sclk", 40'(sclk), 40'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("post_reset_outputs", {32'(din), 2'b0, addr}, {32'h0, 8'd1});
    chk("post_reset_pins", {36'h0, csn, sclk, mosi, we}, {36'h0, 4'b1100});
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (addr !== 6'd1 || csn !== 1'b1 || sclk !== 1'b1 || we !== 1'b0) bad++;
    end
    chk("idle_poll_bad_cycles", 40'(bad), 40'd0);

    // Seven entries, H=8, miso held high.
    sw_write(0, 32'h0000_0807);
    sw_write(5, 32'h0403_0201);
    sw_write(6, 32'h0007_0605);
    for (int i = 0; i < 7; i++) begin
      push_fr({8'(i + 1), 32'h0}, 648, 16);
      push_wr(6'(32 + i), 32'hFFFF_FFFF);
      push_wr(6'd2, 32'h0000_00FF);
    end
    push_wr(6'd1, 32'h0);
    sw_write(1, 32'h1);
    wait_drain("seq7", 8000);
    for (int i = 0; i < 7; i++) chk("seq7_rx", 40'(mem[32 + i]), 40'hFFFF_FFFF);
    chk("seq7_stat", 40'(mem[2]), 40'hFF);
    chk("seq7_ctrl", 40'(mem[1]), 40'h0);

    // Single entry, write flag address, loopback, H field 0 treated as 1.
    loopback = 1'b1;
    sw_write(0, 32'h0000_0001);
    sw_write(5, 32'h0000_0081);
    sw_write(16, 32'hA5A5_0F0F);
    push_fr(40'h81_A5A5_0F0F, 81, 2);
    push_wr(6'd32, 32'hA5A5_0F0F);
    push_wr(6'd2, 32'h0000_0081);
    push_wr(6'd1, 32'h0);
    sw_write(1, 32'h1);
    wait_drain("loop1", 2000);
    chk("loop1_rx", 40'(mem[32]), 40'hA5A5_0F0F);
    chk("loop1_stat", 40'(mem[2]), 40'h81);

    // Zero entries: GO cleared quickly with no SPI activity.
    sw_write(0, 32'h0);
    nf0 = nframes;
    push_wr(6'd1, 32'h0);
    sw_write(1, 32'h1);
    ok = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (mem[1] == 32'h0) begin ok = 1'b1; break; end
    end
    chk("n0_ctrl_cleared_within_5", 40'(ok), 40'd1);
    repeat (10) @(negedge clk);
    chk("n0_no_frames", 40'(nframes - nf0), 40'd0);
    chk("n0_writes_drained", 40'(exp_wr.size()), 40'd0);

    // Count 0x20 saturates to 16 entries.
    sw_write(5, 32'h1312_1110);
    sw_write(6, 32'h1716_1514);
    sw_write(7, 32'h1B1A_1918);
    sw_write(8, 32'h1F1E_1D1C);
    sw_write(48, 32'hDEAD_BEEF);
    for (int i = 0; i < 16; i++) sw_write(6'(16 + i), 32'h1000_0000 + 32'(i * 32'h0101));
    sw_write(0, 32'h0000_0120);
    nf0 = nframes;
    for (int i = 0; i < 16; i++) begin
      push_fr({8'(8'h10 + i), 32'h1000_0000 + 32'(i * 32'h0101)}, 81, 2);
      push_wr(6'(32 + i), 32'h1000_0000 + 32'(i * 32'h0101));
      push_wr(6'd2, 32'(8'h10 + i));
    end
    push_wr(6'd1, 32'h0);
    sw_write(1, 32'h1);
    wait_drain("sat16", 4000);
    chk("sat16_frames", 40'(nframes - nf0), 40'd16);
    chk("sat16_last_rx", 40'(mem[47]), 40'h1000_0F0F);
    chk("sat16_word48", 40'(mem[48]), 40'hDEAD_BEEF);
    chk("sat16_stat", 40'(mem[2]), 40'h1F);

    // Reset during bit 20 of the third frame.
    sw_write(0, 32'h0000_0203);
    sw_write(5, 32'h0023_2221);
    sw_write(16, 32'h1111_1111);
    sw_write(17, 32'h2222_2222);
    sw_write(18, 32'h3333_3333);
    for (int k = 34; k < 37; k++) sw_write(6'(k), 32'h5A5A_5A5A);
    for (int i = 0; i < 2; i++) begin
      push_fr({8'(8'h21 + i), 32'h1111_1111 * 32'(i + 1)}, 162, 4);
      push_wr(6'(32 + i), 32'h1111_1111 * 32'(i + 1));
      push_wr(6'd2, 32'(8'h21 + i));
    end
    nf0 = nframes;
    sw_write(1, 32'h1);
    ok = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (nframes == nf0 + 3 && nb >= 19) begin ok = 1'b1; break; end
    end
    chk("abort_reached_frame3_bit20", 40'(ok), 40'd1);
    aborting = 1'b1;
    resetn = 1'b1;
    @(negedge clk);
    chk("abort_pins", {36'h0, csn, sclk, mosi, we}, {36'h0, 4'b1100});
    chk("abort_outputs", {32'(din), 2'b0, addr}, {32'h0, 8'd1});
    chk("abort_go_left_set", 40'(mem[1]), 40'h1);
    sw_write(1, 32'h0);
    resetn = 1'b0;
    repeat (20) @(negedge clk);
    for (int k = 34; k < 37; k++) chk("abort_untouched", 40'(mem[k]), 40'h5A5A_5A5A);
    chk("abort_stat_frame2", 40'(mem[2]), 40'h22);
    chk("abort_queues_empty", 40'(exp_wr.size() + exp_fr.size()), 40'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
